// File: rtl/mips_div_pkg.sv
// Shared definitions for the MIPS sequential divider: FSM states,
// default operand width and the divide-by-zero quotient pattern.
package mips_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH = 32;

    // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
    localparam logic [63:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    // The shifted remainder needs WIDTH+1 bits; the kept difference is always
    // below the divisor, so the low WIDTH bits of the subtraction suffice.
    assign w_shift = {i_rem, i_bit};
    assign o_qbit  = (w_shift >= {1'b0, i_div});
    assign w_diff  = w_shift[WIDTH-1:0] - i_div;
    assign o_rem   = o_qbit ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/mips_divider.sv
// Iterative restoring DIV/DIVU: one quotient bit per clock, Done WIDTH+2 cycles after Start
// (1 cycle for B == 0); Start is ignored while Busy. Signed mode needs MIPS_DIVIDER_SIGNED_EN.
module mips_divider
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero,
    output logic             Overflow
);

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dbz;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_q_out;
    logic [WIDTH-1:0] r_r_out;
    logic             r_dbz_out;
    logic             r_ovf_out;

    logic             w_neg_a;
    logic             w_neg_b;
    logic             w_ovf;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_q;

    always_comb begin
        w_neg_a = 1'b0;
        w_neg_b = 1'b0;
        w_ovf   = 1'b0;
`ifdef MIPS_DIVIDER_SIGNED_EN
        w_neg_a = Signed & A[WIDTH-1];
        w_neg_b = Signed & B[WIDTH-1];
        w_ovf   = Signed & (A == MIN_NEG) & (&B);
`else
        // Unsigned-only build: the Signed request has no effect.
        w_neg_a = Signed & 1'b0;
`endif
        w_abs_a = w_neg_a ? -A : A;
        w_abs_b = w_neg_b ? -B : B;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_quo[WIDTH-1]),
        .i_div  (r_div),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_q)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_q_out   <= '0;
            r_r_out   <= '0;
            r_dbz_out <= 1'b0;
            r_ovf_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Busy stays up through the Done cycle, so a Start there is dropped.
                    if (r_done) begin
                        r_busy <= 1'b0;
                    end else if (Start && !r_busy) begin
                        r_busy  <= 1'b1;
                        r_quo   <= (B == '0) ? A : w_abs_a;
                        r_div   <= w_abs_b;
                        r_rem   <= '0;
                        r_cnt   <= CNT_W'(WIDTH - 1);
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_dbz   <= (B == '0);
                        r_ovf   <= w_ovf;
                        r_state <= (B == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_step_q};
                    if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (r_neg_q) r_quo <= -r_quo;
                    if (r_neg_r) r_rem <= -r_rem;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    // On divide-by-zero r_quo still holds the raw dividend.
                    r_q_out   <= r_dbz ? DIV_ZERO_QUO[WIDTH-1:0] : r_quo;
                    r_r_out   <= r_dbz ? r_quo : r_rem;
                    r_dbz_out <= r_dbz;
                    r_ovf_out <= r_ovf;
                    r_done    <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Quotient  = r_q_out;
    assign Remainder = r_r_out;
    assign DivByZero = r_dbz_out;
    assign Overflow  = r_ovf_out;

endmodule

// File: tb/tb_mips_divider.sv
// Randomized and directed checks of mips_divider against an arithmetic reference model.
module tb_mips_divider;

`ifdef MIPS_DIVIDER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        Clock   = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start   = 1'b0;
    logic        Signed  = 1'b0;
    logic [31:0] A       = '0;
    logic [31:0] B       = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        DivByZero;
    logic        Overflow;

    int n_vec = 0;
    int n_err = 0;

    mips_divider #(.WIDTH(32)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Signed    (Signed),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero),
        .Overflow  (Overflow)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output bit dz, output bit ov);
        longint sa, sb, tq, tr;
        dz = (b == 0);
        ov = 1'b0;
        if (dz) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && SIGNED_EN) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[31:0];
            r  = tr[31:0];
            ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic finish_op(input string tag, input int start_lat, input int exp_lat,
                             input logic [31:0] eq, input logic [31:0] er,
                             input bit ed, input bit eo);
        int lat;
        bit got;
        lat = start_lat;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge Clock); #1;
            lat++;
            got = Done;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_quotient"}, Quotient, eq);
        chk({tag, "_remainder"}, Remainder, er);
        chk({tag, "_divbyzero"}, DivByZero, ed);
        chk({tag, "_overflow"}, Overflow, eo);
        chk({tag, "_busy_at_done"}, Busy, 1);
        @(posedge Clock); #1;
        chk({tag, "_done_width"}, Done, 0);
        chk({tag, "_busy_fall"}, Busy, 0);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                         input string tag);
        logic [31:0] eq, er;
        bit ed, eo;
        model(a, b, s, eq, er, ed, eo);
        @(negedge Clock);
        A = a; B = b; Signed = s; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        chk({tag, "_busy_rise"}, Busy, 1);
        finish_op(tag, 0, (b == 0) ? 1 : 34, eq, er, ed, eo);
    endtask

    initial begin
        logic [31:0] eq, er, ra, rb;
        bit ed, eo, rs;
        int done_seen;

        repeat (2) @(posedge Clock);
        #1;
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_quotient", Quotient, 0);
        chk("reset_remainder", Remainder, 0);
        chk("reset_divbyzero", DivByZero, 0);
        chk("reset_overflow", Overflow, 0);
        @(negedge Clock);
        Reset_n = 1'b1;

        do_op(32'd36, 32'd21, 1'b0, "unsigned");
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, "signed");
        do_op(32'h1234_5678, 32'd0, 1'b0, "divzero");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "overflow");
        do_op(32'h8000_0001, 32'd0, 1'b1, "divzero_signed");
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, "max_by_one");

        // Second Start at cycle 10 of a running operation must be ignored.
        model(32'd100, 32'd7, 1'b0, eq, er, ed, eo);
        @(negedge Clock);
        A = 32'd100; B = 32'd7; Signed = 1'b0; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (9) @(posedge Clock);
        @(negedge Clock);
        A = 32'd5; B = 32'd1; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        chk("busy_restart_busy", Busy, 1);
        finish_op("busy_restart", 10, 34, eq, er, ed, eo);

        // Asynchronous reset in the middle of a division.
        @(negedge Clock);
        A = 32'd1000; B = 32'd3; Signed = 1'b0; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (19) @(posedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("midreset_busy", Busy, 0);
        chk("midreset_done", Done, 0);
        chk("midreset_quotient", Quotient, 0);
        chk("midreset_remainder", Remainder, 0);
        chk("midreset_divbyzero", DivByZero, 0);
        chk("midreset_overflow", Overflow, 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge Clock); #1;
            if (Done) done_seen++;
        end
        chk("midreset_no_done", done_seen, 0);
        chk("midreset_idle_busy", Busy, 0);
        do_op(32'd1000, 32'd3, 1'b0, "post_reset");

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = $urandom >> $urandom_range(0, 31);
                3:       rb = -($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            if (i == 7) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            do_op(ra, rb, rs, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
